// File: rtl/cmd_conditioner_pkg.sv
// Shared definitions for the up/down command conditioner and frequency divider.
// Holds debounce state encodings, default debounce length and divider terminal count.
package cmd_conditioner_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        RISE_CHK = 2'b01,
        PRESSED  = 2'b10,
        FALL_CHK = 2'b11
    } deb_state_e;

    // 20 ms at 50 MHz
    localparam int DEB_CYCLES_DEF = 1_000_000;
    localparam int CNT_W_DEF      = 20;

    // Divider and conditioner must agree on the slow tick rate
    localparam int CLK_HZ   = 50_000_000;
    localparam int TICK_HZ  = 1;
    localparam int DIV_TERM = CLK_HZ / TICK_HZ - 1;

endpackage

// File: rtl/cmd_conditioner_debounce_fsm.sv
// Two-flop synchronizer plus 4-state debounce FSM for one switch input.
// Ports: Clock, Reset (async, active-high), raw (async level), strobe (1-cycle press pulse).
module debounce_fsm
    import cmd_conditioner_pkg::*;
#(
    parameter int DEB_CYCLES = DEB_CYCLES_DEF,
    parameter int CNT_W      = CNT_W_DEF
) (
    input  logic Clock,
    input  logic Reset,
    input  logic raw,
    output logic strobe
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    logic [1:0]       sync_q, sync_d;
    deb_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             s;

    assign s = sync_q[1];

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (c == CNT_MAX) ? c : c + 1'b1;
    endfunction

    always_comb begin
        sync_d  = {sync_q[0], raw};
        state_d = state_q;
        cnt_d   = cnt_q;
        strobe  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (s) begin
                    state_d = RISE_CHK;
                    cnt_d   = '0;
                end
            end
            RISE_CHK: begin
                if (!s) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q >= CNT_LAST) begin
                    state_d = PRESSED;
                    cnt_d   = '0;
                    strobe  = 1'b1;
                end else begin
                    cnt_d = sat_inc(cnt_q);
                end
            end
            PRESSED: begin
                if (!s) begin
                    state_d = FALL_CHK;
                    cnt_d   = '0;
                end
            end
            FALL_CHK: begin
                if (s) begin
                    // release bounce: still held, no new strobe
                    state_d = PRESSED;
                    cnt_d   = '0;
                end else if (cnt_q >= CNT_LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = sat_inc(cnt_q);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            sync_q  <= '0;
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            sync_q  <= sync_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: rtl/cmd_conditioner.sv
// Turns raw Up/Down switch levels into debounced one-shot commands held for one tick period.
// Ports: Clock, Reset (async, active-high), tick, up_raw, down_raw -> Up, Down, busy.
module cmd_conditioner
    import cmd_conditioner_pkg::*;
#(
    parameter int DEB_CYCLES = DEB_CYCLES_DEF,
    parameter int CNT_W      = CNT_W_DEF
) (
    input  logic Clock,
    input  logic Reset,
    input  logic tick,
    input  logic up_raw,
    input  logic down_raw,
    output logic Up,
    output logic Down,
    output logic busy
);

    logic up_strobe, down_strobe;
    logic pend_up_q, pend_up_d;
    logic pend_dn_q, pend_dn_d;
    logic up_q, up_d;
    logic dn_q, dn_d;

    debounce_fsm #(
        .DEB_CYCLES(DEB_CYCLES),
        .CNT_W     (CNT_W)
    ) u_deb_up (
        .Clock (Clock),
        .Reset (Reset),
        .raw   (up_raw),
        .strobe(up_strobe)
    );

    debounce_fsm #(
        .DEB_CYCLES(DEB_CYCLES),
        .CNT_W     (CNT_W)
    ) u_deb_dn (
        .Clock (Clock),
        .Reset (Reset),
        .raw   (down_raw),
        .strobe(down_strobe)
    );

    // A strobe coinciding with tick re-sets the flag, so it is
    // presented on the following tick instead of being lost.
    always_comb begin
        pend_up_d = (pend_up_q & ~tick) | up_strobe;
        pend_dn_d = (pend_dn_q & ~tick) | down_strobe;
        up_d      = tick ? pend_up_q : up_q;
        dn_d      = tick ? pend_dn_q : dn_q;
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            pend_up_q <= 1'b0;
            pend_dn_q <= 1'b0;
            up_q      <= 1'b0;
            dn_q      <= 1'b0;
        end else begin
            pend_up_q <= pend_up_d;
            pend_dn_q <= pend_dn_d;
            up_q      <= up_d;
            dn_q      <= dn_d;
        end
    end

    assign Up   = up_q;
    assign Down = dn_q;
    assign busy = pend_up_q | pend_dn_q | up_q | dn_q;

endmodule

// File: tb/tb_cmd_conditioner.sv
// Directed bench for cmd_conditioner with DEB_CYCLES=4.
// Cycle 0 of each window is the first cycle after a tick edge.
module tb_cmd_conditioner;

    logic Clock = 1'b0;
    logic Reset;
    logic tick;
    logic up_raw;
    logic down_raw;
    logic Up;
    logic Down;
    logic busy;

    int nerr = 0;
    int nchk = 0;
    int tper = 10;
    int tcnt = 0;

    int first_up, n_up, first_dn, n_dn, n_both, first_busy, n_busy;

    always #5 Clock = ~Clock;

    cmd_conditioner #(
        .DEB_CYCLES(4),
        .CNT_W     (4)
    ) dut (
        .Clock   (Clock),
        .Reset   (Reset),
        .tick    (tick),
        .up_raw  (up_raw),
        .down_raw(down_raw),
        .Up      (Up),
        .Down    (Down),
        .busy    (busy)
    );

    task automatic check(input string tag, input int got, input int exp);
        nchk++;
        if (got != exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge Clock);
        #1;
        tcnt = (tcnt >= tper - 1) ? 0 : tcnt + 1;
        tick = (tcnt == tper - 1);
    endtask

    task automatic align();
        int k = 0;
        while (!tick && k < 100) begin
            step();
            k++;
        end
        check("align_tick", int'(tick), 1);
        step();
    endtask

    task automatic drain(input int n);
        up_raw   = 1'b0;
        down_raw = 1'b0;
        repeat (n) step();
    endtask

    // Up driven high in [ua,ub) and [uc,ud), Down in [da,db).
    task automatic run(input bit do_align, input int n,
                       input int ua, input int ub,
                       input int uc, input int ud,
                       input int da, input int db);
        if (do_align) align();
        first_up = -1; first_dn = -1; first_busy = -1;
        n_up = 0; n_dn = 0; n_both = 0; n_busy = 0;
        for (int i = 0; i < n; i++) begin
            up_raw   = (i >= ua && i < ub) || (i >= uc && i < ud);
            down_raw = (i >= da && i < db);
            if (Up) begin
                if (first_up < 0) first_up = i;
                n_up++;
            end
            if (Down) begin
                if (first_dn < 0) first_dn = i;
                n_dn++;
            end
            if (Up && Down) n_both++;
            if (busy) begin
                if (first_busy < 0) first_busy = i;
                n_busy++;
            end
            step();
        end
    endtask

    initial begin
        Reset    = 1'b1;
        tick     = 1'b0;
        up_raw   = 1'b0;
        down_raw = 1'b0;
        repeat (3) step();
        check("rst_up", int'(Up), 0);
        check("rst_down", int'(Down), 0);
        check("rst_busy", int'(busy), 0);
        Reset = 1'b0;
        drain(5);

        // held press: strobe cycle 6, pend 7, tick at 9, Up 10..19
        run(1, 40, 0, 40, 0, 0, 0, 0);
        check("hold_up_first", first_up, 10);
        check("hold_up_count", n_up, 10);
        check("hold_down_count", n_dn, 0);
        check("hold_busy_first", first_busy, 7);
        check("hold_busy_count", n_busy, 13);
        drain(40);

        run(1, 30, 0, 3, 0, 0, 0, 0);
        check("glitch_up_count", n_up, 0);
        check("glitch_busy_count", n_busy, 0);
        drain(20);

        // strobe at cycle 9 coincides with tick; Down 20..29
        run(1, 40, 0, 0, 0, 0, 3, 40);
        check("ontick_down_first", first_dn, 20);
        check("ontick_down_count", n_dn, 10);
        check("ontick_up_count", n_up, 0);
        check("ontick_busy_first", first_busy, 10);
        drain(40);

        run(1, 40, 0, 40, 0, 0, 0, 40);
        check("both_up_first", first_up, 10);
        check("both_down_first", first_dn, 10);
        check("both_overlap", n_both, 10);
        check("both_up_count", n_up, 10);
        drain(40);

        // two debounced presses need >=10 cycles between strobes,
        // so the tick gap is widened to fit both before one tick
        tper = 30;
        run(1, 70, 0, 5, 10, 70, 0, 0);
        check("twice_up_first", first_up, 30);
        check("twice_up_count", n_up, 30);
        check("twice_busy_first", first_busy, 7);
        check("twice_busy_count", n_busy, 53);
        drain(40);
        tper = 10;

        // reset in the middle of a presentation
        align();
        up_raw = 1'b1;
        repeat (15) step();
        check("mid_up_before", int'(Up), 1);
        #2 Reset = 1'b1;
        #1;
        check("mid_up_async", int'(Up), 0);
        check("mid_down_async", int'(Down), 0);
        check("mid_busy_async", int'(busy), 0);
        up_raw = 1'b0;
        repeat (3) step();
        Reset = 1'b0;
        run(0, 50, 0, 0, 0, 0, 0, 0);
        check("post_rst_busy", n_busy, 0);
        check("post_rst_up", n_up, 0);

        // switch held across reset produces one fresh command
        drain(10);
        align();
        up_raw = 1'b1;
        repeat (8) step();
        check("held_busy_before", int'(busy), 1);
        #2 Reset = 1'b1;
        #1;
        check("held_busy_async", int'(busy), 0);
        repeat (2) step();
        Reset = 1'b0;
        run(0, 40, 0, 40, 0, 0, 0, 0);
        check("held_up_count", n_up, 10);
        check("held_down_count", n_dn, 0);
        drain(10);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
